ysyx_22050133_idq: RTL and testbench

YSYX_22050133_IDQ -- requirements
Module: ysyx_22050133_IDQ

---
 rtl/ysyx_22050133_idq_if.sv | 30 +++
 rtl/ysyx_22050133_idq.sv | 106 ++++++++++
 tb/tb_ysyx_22050133_idq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050133_idq_if.sv
// ysyx_22050133_idq_if: IFU-to-EXU instruction queue handshake and decoded head bundle
interface ysyx_22050133_idq_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;
  logic            flush;
  logic            has_hazard;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;
  logic [CW-1:0]   count;
  modport master (
    output in_valid, in_pc, in_inst, flush, has_hazard, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_illegal, count
  );
  modport slave (
    input  in_valid, in_pc, in_inst, flush, has_hazard, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_illegal, count
  );
endinterface

// File: rtl/ysyx_22050133_idq.sv
// ysyx_22050133_idq: circular instruction queue between IFU and EXU with combinational head decode
module ysyx_22050133_idq #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  ysyx_22050133_idq_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  logic [XLEN-1:0] r_pc   [DEPTH];
  logic [31:0]     r_inst [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [CW-1:0]   r_cnt;

  logic        w_push;
  logic        w_pop;
  logic [31:0] w_inst;
  logic [6:0]  w_op;
  logic        w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st;
  logic        w_opi, w_op_r, w_misc, w_sys, w_opi32, w_op32;
  logic        w_itype;
  logic [63:0] w_imm;

  assign io.in_ready  = r_cnt != CW'(DEPTH);
  assign io.out_valid = (r_cnt != '0) && !io.has_hazard;
  assign io.count     = r_cnt;
  assign w_push = io.in_valid && io.in_ready && !io.flush;
  assign w_pop  = io.out_valid && io.out_ready && !io.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (io.flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_push);
      r_rp  <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wp]   <= io.in_pc;
      r_inst[r_wp] <= io.in_inst;
    end
  end

  assign w_inst  = r_inst[r_rp];
  assign w_op    = w_inst[6:0];
  assign w_lui   = w_op == OP_LUI;
  assign w_auipc = w_op == OP_AUIPC;
  assign w_jal   = w_op == OP_JAL;
  assign w_jalr  = w_op == OP_JALR;
  assign w_br    = w_op == OP_BRANCH;
  assign w_ld    = w_op == OP_LOAD;
  assign w_st    = w_op == OP_STORE;
  assign w_opi   = w_op == OP_IMM;
  assign w_op_r  = w_op == OP_OP;
  assign w_misc  = w_op == OP_MISC;
  assign w_sys   = w_op == OP_SYSTEM;
  assign w_opi32 = w_op == OP_IMM32;
  assign w_op32  = w_op == OP_OP32;
  assign w_itype = w_jalr || w_ld || w_opi || w_opi32 || w_sys;

  // Immediates are built at 64 bits and truncated, which sign-extends correctly for either XLEN.
  always_comb begin
    w_imm = w_itype ? {{52{w_inst[31]}}, w_inst[31:20]} :
            w_st    ? {{52{w_inst[31]}}, w_inst[31:25], w_inst[11:7]} :
            w_br    ? {{51{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0} :
            (w_lui || w_auipc) ? {{32{w_inst[31]}}, w_inst[31:12], 12'b0} :
            w_jal   ? {{43{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0} :
            64'd0;
  end

  assign io.out_pc      = r_pc[r_rp];
  assign io.out_rs1     = (w_lui || w_auipc || w_jal) ? 5'd0 : w_inst[19:15];
  assign io.out_rs2     = (w_br || w_st || w_op_r || w_op32) ? w_inst[24:20] : 5'd0;
  assign io.out_rd      = (w_br || w_st) ? 5'd0 : w_inst[11:7];
  assign io.out_imm     = w_imm[XLEN-1:0];
  assign io.out_illegal = !(w_lui || w_auipc || w_jal || w_jalr || w_br || w_ld || w_st ||
                            w_opi || w_op_r || w_misc || w_sys ||
                            ((w_opi32 || w_op32) && (XLEN == 64)));
endmodule

// File: tb/tb_ysyx_22050133_idq.sv
// tb_ysyx_22050133_idq: directed stimulus with an expected-entry scoreboard drained by a pop monitor
module tb_ysyx_22050133_idq;
  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic        ill;
  } ent_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  ent_t q64[$];
  ent_t q32[$];
  logic [31:0] ins [6];
  logic [63:0] pcs [6];
  ent_t        ev  [6];

  ysyx_22050133_idq_if #(.XLEN(64), .DEPTH(4)) a ();
  ysyx_22050133_idq_if #(.XLEN(32), .DEPTH(4)) b ();
  ysyx_22050133_idq #(.XLEN(64), .DEPTH(4)) u64 (.clk(clk), .rst(rst), .io(a.slave));
  ysyx_22050133_idq #(.XLEN(32), .DEPTH(4)) u32 (.clk(clk), .rst(rst), .io(b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ent_t ent(input logic [63:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] rd, input logic [63:0] imm, input logic ill);
    ent_t e;
    e.pc = pc; e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cmp(input string nm, input ent_t act, input ent_t e);
    chk({nm, "_pc"}, act.pc, e.pc);
    chk({nm, "_rs1"}, 64'(act.rs1), 64'(e.rs1));
    chk({nm, "_rs2"}, 64'(act.rs2), 64'(e.rs2));
    chk({nm, "_rd"}, 64'(act.rd), 64'(e.rd));
    chk({nm, "_imm"}, act.imm, e.imm);
    chk({nm, "_ill"}, 64'(act.ill), 64'(e.ill));
  endtask

  task automatic monitor();
    ent_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (a.out_valid && a.out_ready && !a.flush) begin
          if (q64.size() == 0) begin
            total++; bad++;
            $display("FAIL d64_extra_pop: got pc %0h want no entry", a.out_pc);
          end else begin
            e = q64.pop_front();
            cmp("d64", ent(a.out_pc, a.out_rs1, a.out_rs2, a.out_rd, a.out_imm, a.out_illegal), e);
          end
        end
        if (b.out_valid && b.out_ready && !b.flush) begin
          if (q32.size() == 0) begin
            total++; bad++;
            $display("FAIL d32_extra_pop: got pc %0h want no entry", b.out_pc);
          end else begin
            e = q32.pop_front();
            cmp("d32", ent(64'(b.out_pc), b.out_rs1, b.out_rs2, b.out_rd, 64'(b.out_imm), b.out_illegal), e);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0;
    ins[0] = 32'h123452B7; pcs[0] = 64'h1000; ev[0] = ent(64'h1000, 0, 0, 5, 64'h12345000, 0);
    ins[1] = 32'hFE63AE23; pcs[1] = 64'h1004; ev[1] = ent(64'h1004, 7, 6, 0, 64'hFFFFFFFFFFFFFFFC, 0);
    ins[2] = 32'hFE208CE3; pcs[2] = 64'h1008; ev[2] = ent(64'h1008, 1, 2, 0, 64'hFFFFFFFFFFFFFFF8, 0);
    ins[3] = 32'h005201B3; pcs[3] = 64'h100C; ev[3] = ent(64'h100C, 4, 5, 3, 64'h0, 0);
    ins[4] = 32'hFFFFFFFF; pcs[4] = 64'h1010; ev[4] = ent(64'h1010, 31, 0, 31, 64'h0, 1);
    ins[5] = 32'h010100E7; pcs[5] = 64'h1014; ev[5] = ent(64'h1014, 2, 0, 1, 64'h10, 0);
    rst = 1'b0;
    a.in_valid = 0; a.in_pc = '0; a.in_inst = '0; a.flush = 0; a.has_hazard = 0; a.out_ready = 0;
    b.in_valid = 0; b.in_pc = '0; b.in_inst = '0; b.flush = 0; b.has_hazard = 0; b.out_ready = 0;
    #2;
    chk("rst_count", 64'(a.count), 0);
    chk("rst_out_valid", 64'(a.out_valid), 0);
    chk("rst_in_ready", 64'(a.in_ready), 1);
    fork monitor(); join_none
    tick(); tick();
    rst = 1'b1;
    // single addi, popped one cycle after it becomes visible
    a.in_valid = 1; a.in_pc = 64'h80000000; a.in_inst = 32'h00500093; a.out_ready = 1;
    q64.push_back(ent(64'h80000000, 0, 0, 1, 64'd5, 0));
    tick();
    a.in_valid = 0;
    chk("t1_count", 64'(a.count), 1);
    chk("t1_out_valid", 64'(a.out_valid), 1);
    tick();
    chk("t1_drain", 64'(a.count), 0);
    // fill to capacity; fifth offer is held
    a.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      a.in_valid = 1; a.in_pc = pcs[i]; a.in_inst = ins[i];
      if (i < 4) q64.push_back(ev[i]);
      tick();
      if (i == 3) chk("t2_full_ready", 64'(a.in_ready), 0);
    end
    chk("t2_count", 64'(a.count), 4);
    chk("t2_held_ready", 64'(a.in_ready), 0);
    // full with pop: no push this cycle, push accepted the next
    a.out_ready = 1;
    tick();
    chk("t3_count_pop", 64'(a.count), 3);
    q64.push_back(ev[4]);
    tick();
    a.in_valid = 0;
    chk("t3_count_keep", 64'(a.count), 3);
    // hazard stall
    a.has_hazard = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t4_hz_valid", 64'(a.out_valid), 0);
      chk("t4_hz_count", 64'(a.count), 3);
      tick();
    end
    a.has_hazard = 0;
    #1;
    chk("t4_valid_back", 64'(a.out_valid), 1);
    chk("t4_head_pc", a.out_pc, pcs[2]);
    tick();
    chk("t4_count", 64'(a.count), 2);
    // flush beats a simultaneous push and pop
    a.flush = 1; a.in_valid = 1; a.in_pc = pcs[5]; a.in_inst = ins[5];
    tick();
    a.flush = 0; a.in_valid = 0;
    q64.delete();
    chk("t5_count", 64'(a.count), 0);
    chk("t5_out_valid", 64'(a.out_valid), 0);
    tick();
    chk("t5_nocapture", 64'(a.count), 0);
    // XLEN-dependent decode: jal/addw on 64, addiw/addw illegal on 32
    a.in_valid = 1; a.in_pc = 64'h80000010; a.in_inst = 32'h800000EF;
    q64.push_back(ent(64'h80000010, 0, 0, 1, 64'hFFFFFFFFFFF00000, 0));
    b.in_valid = 1; b.out_ready = 1; b.in_pc = 32'h100; b.in_inst = 32'hFFF0811B;
    q32.push_back(ent(64'h100, 1, 0, 2, 64'hFFFFFFFF, 1));
    tick();
    a.in_pc = 64'h80000014; a.in_inst = 32'h003100BB;
    q64.push_back(ent(64'h80000014, 2, 3, 1, 64'h0, 0));
    b.in_pc = 32'h104; b.in_inst = 32'h003100BB;
    q32.push_back(ent(64'h104, 2, 3, 1, 64'h0, 1));
    tick();
    a.in_valid = 0; b.in_valid = 0;
    tick(); tick();
    chk("t6_count64", 64'(a.count), 0);
    chk("t6_count32", 64'(b.count), 0);
    // asynchronous reset mid-operation
    a.out_ready = 0;
    a.in_valid = 1; a.in_pc = pcs[0]; a.in_inst = ins[0];
    tick();
    a.in_pc = pcs[1]; a.in_inst = ins[1];
    tick();
    a.in_valid = 0;
    chk("t7_count_pre", 64'(a.count), 2);
    #2;
    rst = 1'b0;
    #1;
    chk("t7_rst_count", 64'(a.count), 0);
    chk("t7_rst_valid", 64'(a.out_valid), 0);
    chk("t7_rst_ready", 64'(a.in_ready), 1);
    tick();
    rst = 1'b1;
    a.in_valid = 1; a.in_pc = pcs[3]; a.in_inst = ins[3]; a.out_ready = 1;
    q64.push_back(ev[3]);
    tick();
    a.in_valid = 0;
    chk("t7_first_push", 64'(a.count), 1);
    tick();
    chk("t7_drain", 64'(a.count), 0);
    chk("q64_empty", 64'(q64.size()), 0);
    chk("q32_empty", 64'(q32.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
